// File: rtl/sap2_kbd_pkg.sv
// Shared types and helpers for the SAP-2 hex keyboard encoder: FSM states,
// matrix geometry and the row/column to key-code encoding.
package sap2_kbd_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        WAIT_ACK,
        RELEASE
    } kbd_state_t;

    localparam int KBD_ROWS   = 4;
    localparam int KBD_COLS   = 4;
    localparam int KBD_CODE_W = 4;

    localparam logic [KBD_COLS-1:0] KBD_IDLE_COLS = 4'b1110;

    // Index of the lowest active-low bit; the lowest row wins on multi-key presses.
    function automatic logic [1:0] lowest_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Code = 4*row + col, i.e. row index in the upper two bits.
    function automatic logic [KBD_CODE_W-1:0] key_code(input logic [KBD_ROWS-1:0] rows,
                                                       input logic [KBD_COLS-1:0] cols);
        return {lowest_low(rows), lowest_low(cols)};
    endfunction

endpackage

// File: rtl/sap2_kbd_debouncer.sv
// Consecutive-match counter: o_stable pulses on the cycle the STABLE_CYCLES-th
// consecutive match is seen. Used for both press and release qualification.
module sap2_kbd_debouncer #(
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic i_en,
    input  logic i_match,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_stable = i_en && i_match && (r_cnt == LAST);

    // Count rearms on the stable pulse so back-to-back uses start from zero.
    always_ff @(posedge clk) begin
        if (srst || !i_en || !i_match || o_stable) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sap2_hex_keyboard_encoder.sv
// 4x4 hex keypad scanner with debounce and READY/acknowledge handshake.
// Define SAP2_KBD_NIBBLE_PACK_EN to pack two accepted keys into one byte.
module sap2_hex_keyboard_encoder
    import sap2_kbd_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                CLK,
    input  logic                CLR,
    output logic [KBD_COLS-1:0] col_drive,
    input  logic [KBD_ROWS-1:0] row_sense,
    output logic [7:0]          Keyboard,
    output logic                ready,
    input  logic                acknowedge
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

    kbd_state_t               r_state;
    logic [KBD_COLS-1:0]      r_col_drive;
    logic [KBD_ROWS-1:0]      r_rows;
    logic [CNT_W-1:0]         r_scan_cnt;
    logic [7:0]               r_keyboard;
    logic                     r_ready;
`ifdef SAP2_KBD_NIBBLE_PACK_EN
    logic [KBD_CODE_W-1:0]    r_nibble;
    logic                     r_nibble_valid;
`endif

    logic                     w_db_en;
    logic                     w_db_match;
    logic                     w_stable;
    logic [KBD_CODE_W-1:0]    w_code;

    // Same counter qualifies a stable press pattern and then an all-released matrix.
    assign w_db_en    = (r_state == DEBOUNCE) || (r_state == RELEASE);
    assign w_db_match = (r_state == DEBOUNCE) ? (row_sense == r_rows) : (&row_sense);
    assign w_code     = key_code(r_rows, r_col_drive);

    sap2_kbd_debouncer #(
        .STABLE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_debouncer (
        .clk      (CLK),
        .srst     (CLR),
        .i_en     (w_db_en),
        .i_match  (w_db_match),
        .o_stable (w_stable)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state        <= SCAN;
            r_col_drive    <= KBD_IDLE_COLS;
            r_rows         <= '1;
            r_scan_cnt     <= '0;
            r_keyboard     <= 8'h00;
            r_ready        <= 1'b0;
`ifdef SAP2_KBD_NIBBLE_PACK_EN
            r_nibble       <= '0;
            r_nibble_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                SCAN: begin
                    if (r_scan_cnt == SLOT_LAST) begin
                        r_scan_cnt <= '0;
                        if (!(&row_sense)) begin
                            r_rows  <= row_sense;
                            r_state <= DEBOUNCE;
                        end else begin
                            r_col_drive <= {r_col_drive[KBD_COLS-2:0], r_col_drive[KBD_COLS-1]};
                        end
                    end else begin
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    // Scan counter is already zero, so a bounce restarts this column's slot.
                    if (!w_db_match) begin
                        r_state <= SCAN;
                    end else if (w_stable) begin
`ifdef SAP2_KBD_NIBBLE_PACK_EN
                        if (!r_nibble_valid) begin
                            r_nibble       <= w_code;
                            r_nibble_valid <= 1'b1;
                            r_state        <= RELEASE;
                        end else begin
                            r_keyboard     <= {r_nibble, w_code};
                            r_nibble_valid <= 1'b0;
                            r_ready        <= 1'b1;
                            r_state        <= WAIT_ACK;
                        end
`else
                        r_keyboard <= {4'h0, w_code};
                        r_ready    <= 1'b1;
                        r_state    <= WAIT_ACK;
`endif
                    end
                end
                WAIT_ACK: begin
                    if (acknowedge && r_ready) begin
                        r_ready <= 1'b0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_stable) begin
                        r_state     <= SCAN;
                        r_scan_cnt  <= '0;
                        r_col_drive <= {r_col_drive[KBD_COLS-2:0], r_col_drive[KBD_COLS-1]};
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign col_drive = r_col_drive;
    assign Keyboard  = r_keyboard;
    assign ready     = r_ready;

endmodule

// File: tb/tb_sap2_hex_keyboard_encoder.sv
// Self-checking bench: a procedural keypad/handshake model is compared with the
// DUT every cycle, plus directed literal checks and a randomized phase.
module tb_sap2_hex_keyboard_encoder;

    localparam int SDIV = 4;
    localparam int DEB  = 8;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic [7:0]  Keyboard;
    logic        ready;
    logic        acknowedge = 1'b0;
    logic [15:0] keys = 16'h0000;   // bit 4*row+col set = key held down

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // Passive matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        row_sense = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_drive[c] == 1'b0 && keys[4*r+c]) begin
                    row_sense[r] = 1'b0;
                end
            end
        end
    end

    sap2_hex_keyboard_encoder #(
        .SCAN_DIV        (SDIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .col_drive  (col_drive),
        .row_sense  (row_sense),
        .Keyboard   (Keyboard),
        .ready      (ready),
        .acknowedge (acknowedge)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         exp_col   = 0;
    bit         exp_ready = 1'b0;
    logic [7:0] exp_kbd   = 8'h00;
    bit         model_on  = 1'b0;
    bit         m_abort;
    bit         m_ack;

    function automatic logic [3:0] model_rows(input int col);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (keys[4*r+col]) rows[r] = 1'b0;
        end
        return rows;
    endfunction

    function automatic int lowest_row(input logic [3:0] rows);
        int low;
        low = 0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows[r]) low = r;
        end
        return low;
    endfunction

    // Inputs only change on the falling edge, so reading them just after the
    // rising edge yields the values the DUT sampled.
    task automatic m_tick();
        @(posedge CLK);
        m_abort = CLR;
        m_ack   = acknowedge;
    endtask

    task automatic model_run();
        logic [3:0] r;
        logic [3:0] cap;
        int         cnt;
        int         code;
`ifdef SAP2_KBD_NIBBLE_PACK_EN
        int         nib   = 0;
        bit         nib_v = 1'b0;
`endif
        forever begin
            r = 4'hF;
            for (int k = 1; k <= SDIV; k++) begin
                m_tick();
                if (m_abort) return;
                if (k == SDIV) r = model_rows(exp_col);
            end
            if (r == 4'hF) begin
                exp_col = (exp_col + 1) % 4;
                continue;
            end
            cap  = r;
            code = 4 * lowest_row(cap) + exp_col;
            cnt  = 0;
            while (cnt < DEB) begin
                m_tick();
                if (m_abort) return;
                if (model_rows(exp_col) == cap) cnt++;
                else break;
            end
            if (cnt < DEB) continue;
`ifdef SAP2_KBD_NIBBLE_PACK_EN
            if (!nib_v) begin
                nib   = code;
                nib_v = 1'b1;
            end else begin
                exp_kbd   = 8'(nib * 16 + code);
                nib_v     = 1'b0;
                exp_ready = 1'b1;
            end
`else
            exp_kbd   = 8'(code);
            exp_ready = 1'b1;
`endif
            if (exp_ready) begin
                do begin
                    m_tick();
                    if (m_abort) return;
                end while (!m_ack);
                exp_ready = 1'b0;
            end
            cnt = 0;
            while (cnt < DEB) begin
                m_tick();
                if (m_abort) return;
                if (model_rows(exp_col) == 4'hF) cnt++;
                else cnt = 0;
            end
            exp_col = (exp_col + 1) % 4;
        end
    endtask

    initial begin : model_proc
        forever begin
            exp_col   = 0;
            exp_ready = 1'b0;
            exp_kbd   = 8'h00;
            model_run();
        end
    end

    always @(negedge CLK) begin
        logic [3:0] one;
        logic [3:0] exp_cd;
        if (model_on) begin
            one    = 4'b0001;
            exp_cd = ~(one << exp_col);
            check("cyc_col_drive", col_drive, exp_cd);
            check("cyc_ready", ready, exp_ready);
            check("cyc_keyboard", Keyboard, exp_kbd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_slot_start(input logic [3:0] pat, input string nm);
        logic [3:0] prev;
        bit         found;
        prev  = col_drive;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            if (col_drive == pat && prev != pat) found = 1'b1;
            prev = col_drive;
        end
        check(nm, found, 1'b1);
    endtask

    task automatic press_mask(input logic [15:0] m, input bit expect_rdy,
                              input logic [7:0] expv, input string nm);
        bit ok;
        bit seen;
        ok   = 1'b0;
        seen = 1'b0;
        keys = m;
        if (expect_rdy) begin
            for (int i = 0; i < 300 && !ok; i++) begin
                @(negedge CLK);
                ok = ready;
            end
            check({nm, "_ready"}, ok, 1'b1);
            check({nm, "_code"}, Keyboard, expv);
            cyc(2);
            acknowedge = 1'b1;
            cyc(1);
            acknowedge = 1'b0;
            check({nm, "_ack"}, ready, 1'b0);
        end else begin
            repeat (60) begin
                @(negedge CLK);
                seen |= ready;
            end
            check({nm, "_noready"}, seen, 1'b0);
        end
        keys = 16'h0000;
        cyc(24);
    endtask

    initial begin : stim
        bit seen;
        bit bad;
        bit rotated;

        // Reset with random key activity
        keys = 16'($urandom);
        @(negedge CLK);
        model_on = 1'b1;
        check("rst_col", col_drive, 4'b1110);
        check("rst_kbd", Keyboard, 8'h00);
        check("rst_ready", ready, 1'b0);
        keys = 16'($urandom);
        @(negedge CLK);
        check("rst2_col", col_drive, 4'b1110);
        CLR  = 1'b0;
        keys = 16'h0000;
        cyc(3);
        check("scan_hold", col_drive, 4'b1110);
        cyc(1);
        check("scan_adv", col_drive, 4'b1101);
        check("model_pin_col", exp_col, 1);

        // Clean press row 2 / col 1 -> 0x09, exactly 8 edges after the detecting sample
`ifdef SAP2_KBD_NIBBLE_PACK_EN
        press_mask(16'h0001, 1'b0, 8'h00, "prime0");
`endif
        wait_slot_start(4'b1101, "slot_col1");
        keys[9] = 1'b1;
        cyc(11);
        check("press_early", ready, 1'b0);
        cyc(1);
        check("press_ready", ready, 1'b1);
        check("press_code", Keyboard, 8'h09);
        check("model_pin_code", exp_kbd, 8'h09);
        cyc(3);
        acknowedge = 1'b1;
        cyc(1);
        acknowedge = 1'b0;
        check("press_ack", ready, 1'b0);
        seen = 1'b0;
        repeat (44) begin
            @(negedge CLK);
            seen |= ready;
        end
        check("no_repeat", seen, 1'b0);
        keys = 16'h0000;
        cyc(24);

        // Bounce on key 0xE: 5 cycles low then released
        wait_slot_start(4'b1011, "slot_col2");
        keys[14] = 1'b1;
        cyc(5);
        keys[14] = 1'b0;
        seen     = 1'b0;
        rotated  = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            seen |= ready;
            if (col_drive == 4'b0111) rotated = 1'b1;
        end
        check("bounce_noready", seen, 1'b0);
        check("bounce_rotate", rotated, 1'b1);

        // Handshake hold on 0x3, ack pulses beforehand are ignored
`ifdef SAP2_KBD_NIBBLE_PACK_EN
        press_mask(16'h0001, 1'b0, 8'h00, "prime1");
`endif
        for (int p = 0; p < 3; p++) begin
            acknowedge = 1'b1;
            cyc(1);
            acknowedge = 1'b0;
            check("early_ack_ready", ready, 1'b0);
            cyc(2);
        end
        keys[3] = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            seen = ready;
        end
        check("hold_ready", seen, 1'b1);
        bad = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            if (ready !== 1'b1 || Keyboard !== 8'h03) bad = 1'b1;
        end
        check("hold_stable", bad, 1'b0);
        check("hold_code", Keyboard, 8'h03);
        acknowedge = 1'b1;
        cyc(1);
        acknowedge = 1'b0;
        check("hold_ack", ready, 1'b0);
        keys = 16'h0000;
        cyc(24);

        // Multi-row press in one column: rows 1 and 3 of col 1 -> lowest row wins
`ifdef SAP2_KBD_NIBBLE_PACK_EN
        press_mask(16'h0001, 1'b0, 8'h00, "prime2");
`endif
        press_mask(16'h2020, 1'b1, 8'h05, "multirow");

        // Pack scenario: 0xA then 0x5
`ifdef SAP2_KBD_NIBBLE_PACK_EN
        press_mask(16'h0400, 1'b0, 8'h00, "packA");
        press_mask(16'h0020, 1'b1, 8'hA5, "packA5");
`else
        press_mask(16'h0400, 1'b1, 8'h0A, "keyA");
        press_mask(16'h0020, 1'b1, 8'h05, "key5");
`endif

        // Reset mid-handshake / after a held first nibble
`ifdef SAP2_KBD_NIBBLE_PACK_EN
        press_mask(16'h0800, 1'b0, 8'h00, "nibB");
        CLR = 1'b1;
        cyc(1);
        check("rst_nib_ready", ready, 1'b0);
        check("rst_nib_kbd", Keyboard, 8'h00);
        CLR = 1'b0;
        press_mask(16'h0080, 1'b0, 8'h00, "nib7");
        press_mask(16'h0002, 1'b1, 8'h71, "pack71");
`else
        keys[12] = 1'b1;
        seen     = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            seen = ready;
        end
        check("wa_ready", seen, 1'b1);
        cyc(2);
        CLR  = 1'b1;
        keys = 16'h0000;
        cyc(1);
        check("rst_wa_ready", ready, 1'b0);
        check("rst_wa_kbd", Keyboard, 8'h00);
        CLR = 1'b0;
        press_mask(16'h0080, 1'b1, 8'h07, "after_rst7");
`endif

        // Randomized phase, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 24) == 0) keys ^= 16'(1 << $urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) keys = 16'h0000;
            acknowedge = ($urandom_range(0, 3) == 0);
            CLR        = ($urandom_range(0, 699) == 0);
        end
        CLR        = 1'b0;
        acknowedge = 1'b0;
        keys       = 16'h0000;
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
